pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and jump-target width in bits.
REQ-002 SHALL have parameter STALL_DIV, default 4, PC advances once per STALL_DIV cycles while stalled; legal range 1..16.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address stack entries; legal range 1..16.
REQ-004 SHALL have ports, clock and reset first: Clk in 1 clock; Reset in 1 sync active-high reset; Start in 1 launch pulse; Halt in 1 stop request; StallCtr in 1 stall request; Jen in 1 branch enable; Zero in 1 ALU zero flag; BrMode in 2 branch mode; Jump in PC_W target or offset; Call in 1 push-and-jump; Ret in 1 pop-and-jump; PC out PC_W program counter; Running out 1 state==RUN; Done out 1 state==DONE; StallAct out 1 stall counter nonzero; RasErr out 1 sticky stack error.
REQ-005 SHALL use one clock, Clk; Reset SHALL be synchronous and active-high.

Function
REQ-006 SHALL implement FSM IDLE, RUN, DONE: IDLE->RUN on Start; RUN->DONE on Halt; DONE->RUN on Start, with PC reloaded to 0; no other transitions.
REQ-007 SHALL hold PC in IDLE and DONE; Start in those states SHALL not itself advance PC that cycle.
REQ-008 SHALL, in RUN, compute next PC with priority Halt (hold) > Ret > Call > taken branch > PC+1.
REQ-009 SHALL decode BrMode when Jen=1: 00 absolute if Zero; 01 absolute if !Zero; 10 absolute unconditional; 11 PC + sign-extended Jump if Zero; Jen=0 means no branch.
REQ-010 SHALL wrap all PC arithmetic modulo 2^PC_W: PC+1 at all-ones gives 0; relative target wraps both directions.
REQ-011 SHALL, while StallCtr=1 in RUN, apply the REQ-008 update only when the stall count is 0; the count increments every cycle, wrapping STALL_DIV-1 -> 0.
REQ-012 SHALL clear the stall count to 0 on any cycle with StallCtr=0 and perform the normal update that cycle; STALL_DIV=1 SHALL make stall transparent.
REQ-013 SHALL sample Jen, Zero, BrMode, Jump, Call and Ret only on update cycles; values on held cycles are ignored.
REQ-014 SHALL assert StallAct when the stall count is nonzero.

Reset
REQ-015 SHALL, on Reset, force state IDLE, PC=0, stall count 0, stack pointer 0, RasErr=0, regardless of state or stall phase.
REQ-016 SHALL give Reset priority over Start, Halt and all other inputs in the same cycle.
REQ-017 SHALL reset Running=0, Done=0, StallAct=0.

Configuration
REQ-018 SHALL compile the return-address stack only when macro PC_SEQ_RAS_EN is defined.
REQ-019 SHALL, with PC_SEQ_RAS_EN: Call pushes PC+1 (wrapped) and loads Jump; Ret loads the popped entry; Call and Ret together treated as Ret.
REQ-020 SHALL, with PC_SEQ_RAS_EN, on push when full drop the push, still jump, set RasErr; on pop when empty load PC+1, set RasErr; RasErr clears only on Reset.
REQ-021 SHALL, without PC_SEQ_RAS_EN, keep Call/Ret ports but ignore them, tie RasErr to 0, and instantiate no stack storage.

Structure
REQ-022 SHALL place BrMode encoding enum and FSM state enum in shared package pc_seq_pkg.
REQ-023 SHALL implement the stack as sub-module pc_ras (parameters PC_W, RAS_DEPTH; push, pop, full, empty, top).
REQ-024 SHALL keep the stall divider and next-PC mux in pc_sequencer.

Verification
REQ-025 SHALL test: Reset, Start, 5 idle cycles -> PC 0,1,2,3,4,5 in RUN; Halt -> Done=1, PC held.
REQ-026 SHALL test: STALL_DIV=4, StallCtr high 8 cycles from PC=3 -> PC 4 on cycle 1 and 5 on cycle 5, StallAct high on counts 1..3.
REQ-027 SHALL test: PC=10, Jen=1, BrMode=11, Zero=1, Jump=8'hFC -> PC=6; same with Zero=0 -> PC=11.
REQ-028 SHALL test: PC=8'hFF, no branch -> PC=0; BrMode=01, Zero=0, Jump=8'h20 -> PC=8'h20.
REQ-029 SHALL test with PC_SEQ_RAS_EN, RAS_DEPTH=2: three Calls from PC=1,0x11,0x21 to 0x10,0x20,0x30 -> third push dropped, RasErr=1; Ret -> PC=0x12.
REQ-030 SHALL test: Reset asserted mid-stall at count 2 with Call pending -> next cycle IDLE, PC=0, StallAct=0, RasErr=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, branch-mode
// encoding, stall counter width and branch-condition decode.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_ABS_Z  = 2'b00,
    BR_ABS_NZ = 2'b01,
    BR_ABS    = 2'b10,
    BR_REL_Z  = 2'b11
  } br_mode_e;

  // Wide enough for a stall phase up to STALL_DIV-1 with STALL_DIV <= 16.
  localparam int STALL_CNT_W = 4;

  function automatic logic br_taken(input logic jen, input logic zero,
                                    input br_mode_e mode);
    logic taken;
    taken = 1'b0;
    if (jen) begin
      case (mode)
        BR_ABS_Z:  taken = zero;
        BR_ABS_NZ: taken = !zero;
        BR_ABS:    taken = 1'b1;
        BR_REL_Z:  taken = zero;
        default:   taken = 1'b0;
      endcase
    end
    return taken;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_sequencer; pop wins over push, and full/empty
// requests are silently ignored here (the caller flags the error).
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [PC_W-1:0] top_o
);

  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(RAS_DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o && !pop_i;
  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_pop)       sp_d = sp_q - SP_W'(1);
    else if (do_push) sp_d = sp_q + SP_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // NOTE: storage has no reset; entries above the stack pointer are never read.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE FSM, stall divider, branch/next-PC mux.
// Optional return-address stack compiled in with macro PC_SEQ_RAS_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int STALL_DIV = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            StallCtr,
  input  logic            Jen,
  input  logic            Zero,
  input  logic [1:0]      BrMode,
  input  logic [PC_W-1:0] Jump,
  input  logic            Call,
  input  logic            Ret,
  output logic [PC_W-1:0] PC,
  output logic            Running,
  output logic            Done,
  output logic            StallAct,
  output logic            RasErr
);

  localparam logic [STALL_CNT_W-1:0] CNT_LAST = STALL_CNT_W'(STALL_DIV - 1);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]        pc_inc, br_target;
  logic                   taken, update;

  assign pc_inc    = pc_q + PC_W'(1);
  // Adding the raw PC_W-bit offset modulo 2^PC_W equals adding it sign-extended.
  assign br_target = (br_mode_e'(BrMode) == BR_REL_Z) ? (pc_q + Jump) : Jump;
  assign taken     = br_taken(Jen, Zero, br_mode_e'(BrMode));

`ifdef PC_SEQ_RAS_EN
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;
  logic            ras_err_q, ras_err_d;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk         (Clk),
    .Reset       (Reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .top_o       (ras_top)
  );

  always_ff @(posedge Clk) begin
    if (Reset) ras_err_q <= 1'b0;
    else       ras_err_q <= ras_err_d;
  end

  assign RasErr = ras_err_q;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = Call ^ Ret;
  assign RasErr            = 1'b0;
`endif

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = '0;
    update  = 1'b0;
`ifdef PC_SEQ_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_err_d = ras_err_q;
`endif
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (StallCtr) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + STALL_CNT_W'(1);
        update = !StallCtr || (cnt_q == '0);
        if (Halt) begin
          state_d = ST_DONE;
        end else if (update) begin
`ifdef PC_SEQ_RAS_EN
          if (Ret) begin
            ras_pop = !ras_empty;
            pc_d    = ras_empty ? pc_inc : ras_top;
            if (ras_empty) ras_err_d = 1'b1;
          end else if (Call) begin
            ras_push = !ras_full;
            pc_d     = Jump;
            if (ras_full) ras_err_d = 1'b1;
          end else if (taken) begin
            pc_d = br_target;
          end else begin
            pc_d = pc_inc;
          end
`else
          if (taken) pc_d = br_target;
          else       pc_d = pc_inc;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC       = pc_q;
  assign Running  = (state_q == ST_RUN);
  assign Done     = (state_q == ST_DONE);
  assign StallAct = (cnt_q != '0);

endmodule
